// File: rtl/set_job_sequencer.sv
// Issues up to DEPTH table jobs to SET via en/busy/valid, records candidates and a running total.
// Define SET_TIMEOUT_EN to add a WAIT watchdog that marks a stalled job 8'hFF and moves on.
module set_job_sequencer #(
   parameter int DEPTH   = 64,
   parameter int AW      = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [23:0]   load_central,
   input  logic [11:0]   load_radius,
   input  logic          start,
   input  logic [1:0]    mode_in,
   input  logic [AW:0]   job_count,
   output logic          en,
   output logic [23:0]   central,
   output logic [11:0]   radius,
   output logic [1:0]    mode,
   input  logic          busy,
   input  logic          valid,
   input  logic [7:0]    candidate,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          running,
   output logic          done,
   output logic [AW-1:0] job_idx,
   output logic [13:0]   total
`ifdef SET_TIMEOUT_EN
   ,
   output logic          timeout_err
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_CNT = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_IDX = AW'(1);

   if (DEPTH != (1 << AW) || TIMEOUT < 2) begin : g_cfg_check
      $error("set_job_sequencer: DEPTH must equal 2**AW and TIMEOUT must be at least 2");
   end

   state_t      state;
   logic [35:0] job_tbl [DEPTH];
   logic [7:0]  res_buf [DEPTH];
   logic [AW:0] count;
   logic        last_job;
   logic        tmo;
   logic        res_we;
   logic [7:0]  res_dat;

   assign last_job = ({1'b0, job_idx} == (count - ONE_CNT));

`ifdef SET_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;
   assign tmo = (state == WAIT) && !valid && (wait_cnt == TW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   // A timed-out job is recorded as 8'hFF so the host can tell it apart.
   assign res_we  = (state == WAIT) && (valid || tmo);
   assign res_dat = valid ? candidate : 8'hFF;

   // Table and result storage survive reset on purpose.
   always_ff @(posedge clk) begin
      if (load_we && state == IDLE) begin
         job_tbl[load_addr] <= {load_central, load_radius};
      end
      if (res_we) begin
         res_buf[job_idx] <= res_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         en      <= 1'b0;
         central <= '0;
         radius  <= '0;
         mode    <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         job_idx <= '0;
         total   <= '0;
         rd_data <= '0;
         count   <= '0;
`ifdef SET_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         en      <= 1'b0;
         done    <= 1'b0;
         rd_data <= res_buf[rd_addr];
         case (state)
            IDLE: begin
               if (start) begin
                  mode    <= mode_in;
                  count   <= (job_count > DEPTH_W) ? DEPTH_W : job_count;
                  job_idx <= '0;
                  total   <= '0;
                  running <= 1'b1;
`ifdef SET_TIMEOUT_EN
                  timeout_err <= 1'b0;
`endif
                  state   <= (job_count == '0) ? FINISH : ISSUE;
               end
            end
            ISSUE: begin
               if (!busy) begin
                  en                <= 1'b1;
                  {central, radius} <= job_tbl[job_idx];
`ifdef SET_TIMEOUT_EN
                  wait_cnt          <= '0;
`endif
                  state             <= WAIT;
               end
            end
            WAIT: begin
               if (valid || tmo) begin
                  if (valid) begin
                     total <= total + {6'd0, candidate};
                  end
`ifdef SET_TIMEOUT_EN
                  if (tmo) begin
                     timeout_err <= 1'b1;
                  end
`endif
                  if (last_job) begin
                     state <= FINISH;
                  end else begin
                     job_idx <= job_idx + ONE_IDX;
                     state   <= ISSUE;
                  end
               end
`ifdef SET_TIMEOUT_EN
               else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
`endif
            end
            FINISH: begin
               done    <= 1'b1;
               running <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_job_sequencer.sv
// Scoreboard bench for set_job_sequencer with a behavioural SET responder.
module tb_set_job_sequencer;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
`ifdef SET_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          load_we;
   logic [AW-1:0] load_addr;
   logic [23:0]   load_central;
   logic [11:0]   load_radius;
   logic          start;
   logic [1:0]    mode_in;
   logic [AW:0]   job_count;
   logic          en;
   logic [23:0]   central;
   logic [11:0]   radius;
   logic [1:0]    mode;
   logic          busy;
   logic          valid;
   logic [7:0]    candidate;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          running;
   logic          done;
   logic [AW-1:0] job_idx;
   logic [13:0]   total;
`ifdef SET_TIMEOUT_EN
   logic          timeout_err;
`endif

   always #5 clk = ~clk;

   set_job_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
      .load_central(load_central), .load_radius(load_radius), .start(start),
      .mode_in(mode_in), .job_count(job_count), .en(en), .central(central),
      .radius(radius), .mode(mode), .busy(busy), .valid(valid),
      .candidate(candidate), .rd_addr(rd_addr), .rd_data(rd_data),
      .running(running), .done(done), .job_idx(job_idx), .total(total)
`ifdef SET_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [35:0] tbl [DEPTH];
   logic [7:0]  exp_res [DEPTH];
   logic [35:0] exp_q [$];
   logic [7:0]  resp_q [$];
   logic [35:0] e;
   logic [1:0]  exp_mode;
   logic        busy_smp;
   logic        en_prev = 1'b0;
   int          exp_total, exp_n;
   int          en_cnt = 0;
   int          done_cnt = 0;
   int          mj = 0;
   int          mj_cur;
   int          busy_cyc = 4;
   int          drop_job = -1;
   int          hold_job = -1;
   int          hold_cyc = 10;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) busy_smp <= busy;

   // Monitor: every issue is popped from the scoreboard and compared.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (en === 1'b1) begin
            en_cnt++;
            check("en_busy_gate", {63'd0, busy_smp}, 64'd0);
            check("en_one_cycle", {63'd0, en_prev}, 64'd0);
            check("mode_hold", {62'd0, mode}, {62'd0, exp_mode});
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("issue_central", {40'd0, central}, {40'd0, e[35:12]});
               check("issue_radius", {52'd0, radius}, {52'd0, e[11:0]});
            end
         end
         if (done === 1'b1) done_cnt++;
         en_prev = en;
      end
   end

   // SET responder: busy for busy_cyc cycles after en, then one valid pulse.
   initial begin : set_model
      busy = 1'b0;
      valid = 1'b0;
      candidate = '0;
      forever begin
         @(negedge clk);
         if (en === 1'b1) begin
            mj_cur = mj;
            mj++;
            busy = 1'b1;
            repeat (busy_cyc) @(negedge clk);
            if (mj_cur != drop_job) begin
               valid = 1'b1;
               candidate = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
               @(negedge clk);
               valid = 1'b0;
               if (mj_cur == hold_job) begin
                  repeat (3) @(negedge clk);
                  valid = 1'b1;
                  candidate = 8'hAA;
                  @(negedge clk);
                  valid = 1'b0;
                  repeat (hold_cyc) @(negedge clk);
               end
            end
            busy = 1'b0;
         end
      end
   end

   task automatic load_job(input int a, input logic [23:0] c, input logic [11:0] r);
      load_we = 1'b1;
      load_addr = AW'(a);
      load_central = c;
      load_radius = r;
      tbl[a] = {c, r};
      tick();
      load_we = 1'b0;
   endtask

   task automatic prep(input int cnt, input logic [1:0] m, input int base, input int step);
      exp_n = (cnt > DEPTH) ? DEPTH : cnt;
      exp_q.delete();
      resp_q.delete();
      en_cnt = 0;
      mj = 0;
      exp_total = 0;
      exp_mode = m;
      for (int i = 0; i < exp_n; i++) begin
         exp_q.push_back(tbl[i]);
         if (i == drop_job) begin
            exp_res[i] = 8'hFF;
         end else begin
            exp_res[i] = 8'(base + step * i);
            resp_q.push_back(exp_res[i]);
            exp_total += int'(exp_res[i]);
         end
      end
   endtask

   task automatic go(input int cnt, input logic [1:0] m);
      start = 1'b1;
      job_count = 7'(cnt);
      mode_in = m;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int k;
      d0 = done_cnt;
      k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_en_count"}, 64'(en_cnt), 64'(exp_n));
      check({tag, "_total"}, {50'd0, total}, 64'(exp_total));
      check({tag, "_job_idx"}, {58'd0, job_idx}, 64'(exp_n - 1));
      @(negedge clk);
      check({tag, "_done_width"}, {63'd0, done}, 64'd0);
      check({tag, "_running_off"}, {63'd0, running}, 64'd0);
   endtask

   task automatic rd_check(input string tag, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         tick();
         rd_addr = AW'(i);
         tick();
         check($sformatf("%s_result[%0d]", tag, i), {56'd0, rd_data}, {56'd0, exp_res[i]});
      end
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_en"}, {63'd0, en}, 64'd0);
      check({tag, "_running"}, {63'd0, running}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_job_idx"}, {58'd0, job_idx}, 64'd0);
      check({tag, "_total"}, {50'd0, total}, 64'd0);
      check({tag, "_mode"}, {62'd0, mode}, 64'd0);
      check({tag, "_central"}, {40'd0, central}, 64'd0);
      check({tag, "_radius"}, {52'd0, radius}, 64'd0);
      check({tag, "_rd_data"}, {56'd0, rd_data}, 64'd0);
`ifdef SET_TIMEOUT_EN
      check({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
`endif
   endtask

   initial begin : stim
      int d0;
      int k;
      rst = 1'b1;
      load_we = 1'b0;
      load_addr = '0;
      load_central = '0;
      load_radius = '0;
      start = 1'b0;
      mode_in = '0;
      job_count = '0;
      rd_addr = '0;
      repeat (3) tick();
      reset_outputs("por");
      rst = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) begin
         load_job(i, 24'($urandom()), 12'($urandom()));
      end

      // Basic batch; job 0 rewritten in the start cycle.
      load_we = 1'b1;
      load_addr = '0;
      load_central = 24'h123456;
      load_radius = 12'hABC;
      tbl[0] = {24'h123456, 12'hABC};
      prep(3, 2'b01, 5, 1);
      go(3, 2'b01);
      load_we = 1'b0;
      wait_done("basic", 500);
      end_checks("basic");
      rd_check("basic", 0, 2);

      // Busy held across the second issue, with a stray valid while in ISSUE.
      hold_job = 0;
      prep(3, 2'b10, 20, 1);
      go(3, 2'b10);
      wait_done("busy", 500);
      end_checks("busy");
      rd_check("busy", 0, 2);
      hold_job = -1;

      // Zero-length batch finishes two cycles after start.
      prep(0, 2'b00, 0, 0);
      go(0, 2'b00);
      @(negedge clk);
      check("zero_done_early", {63'd0, done}, 64'd0);
      check("zero_running", {63'd0, running}, 64'd1);
      @(negedge clk);
      check("zero_done", {63'd0, done}, 64'd1);
      check("zero_en_count", 64'(en_cnt), 64'd0);
      check("zero_total", {50'd0, total}, 64'd0);
      check("zero_job_idx", {58'd0, job_idx}, 64'd0);
      repeat (2) tick();

      // Full table, every candidate 64.
      prep(64, 2'b11, 64, 0);
      go(64, 2'b11);
      wait_done("full", 3000);
      end_checks("full");
      rd_check("full", 62, 63);

      // Oversized count clamps to DEPTH.
      prep(100, 2'b01, 1, 1);
      go(100, 2'b01);
      wait_done("clamp", 3000);
      end_checks("clamp");
      rd_check("clamp", 0, 1);
      rd_check("clamp", 63, 63);

      // start and load_we during a batch are ignored.
      prep(3, 2'b00, 9, 2);
      d0 = done_cnt;
      go(3, 2'b00);
      repeat (4) tick();
      start = 1'b1;
      job_count = 7'd5;
      load_we = 1'b1;
      load_addr = AW'(1);
      load_central = ~tbl[1][35:12];
      load_radius = ~tbl[1][11:0];
      tick();
      start = 1'b0;
      load_we = 1'b0;
      wait_done("ign", 500);
      end_checks("ign");
      repeat (20) tick();
      check("ign_single_done", 64'(done_cnt - d0), 64'd1);
      check("ign_idle", {63'd0, running}, 64'd0);
      prep(3, 2'b10, 30, 1);
      go(3, 2'b10);
      wait_done("ign2", 500);
      end_checks("ign2");

      // Reset in the middle of a batch.
      prep(5, 2'b11, 40, 1);
      go(5, 2'b11);
      k = 0;
      while (en_cnt < 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("mid_reached", 64'(en_cnt), 64'd2);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      reset_outputs("midrst");
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_en", {63'd0, en}, 64'd0);
      repeat (20) tick();
      check("post_rst_no_en", 64'(en_cnt), 64'd2);
      prep(4, 2'b01, 50, 3);
      go(4, 2'b01);
      wait_done("after_rst", 500);
      end_checks("after_rst");
      rd_check("after_rst", 0, 3);

`ifdef SET_TIMEOUT_EN
      drop_job = 1;
      prep(3, 2'b10, 70, 1);
      go(3, 2'b10);
      wait_done("tmo", 500);
      check("tmo_err", {63'd0, timeout_err}, 64'd1);
      end_checks("tmo");
      rd_check("tmo", 0, 2);
      drop_job = -1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_job_sequencer.md
Name: set_job_sequencer

Overview:
- Upstream job driver for the SET circle-coverage engine.
- Holds up to 64 (central, radius) jobs in an internal table and issues them one at a time to SET using the en/busy/valid handshake.
- Captures each candidate count into a result buffer and accumulates a running total.
- Lets the system run a batch of SET jobs without per-pattern host control.

Parameters:
- DEPTH, 64: job/result table entries; must be a power of 2.
- AW, 6: address width, log2(DEPTH).
- TIMEOUT, 1024: watchdog limit in cycles while waiting for valid. Used only with SET_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_we  in  1  job table write strobe
- load_addr  in  AW  job table write address
- load_central  in  24  {Ax,Ay,Bx,By,Cx,Cy}, 4 bits each
- load_radius  in  12  {rA,rB,rC}, 4 bits each
- start  in  1  single-cycle batch start pulse
- mode_in  in  2  SET mode for the batch (00 single, 01 union, 10 diff, 11 intersect)
- job_count  in  AW+1  number of jobs, 0..DEPTH
- en  out  1  to SET: one-cycle job strobe
- central  out  24  to SET
- radius  out  12  to SET
- mode  out  2  to SET, held for the whole batch
- busy  in  1  from SET
- valid  in  1  from SET
- candidate  in  8  from SET
- rd_addr  in  AW  result buffer read address
- rd_data  out  8  result buffer data, 1-cycle read latency
- running  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end
- job_idx  out  AW  index of the current job
- total  out  14  sum of candidates in the current batch
- timeout_err  out  1  sticky watchdog flag; present only with SET_TIMEOUT_EN

Behaviour:
- Reset values: en=0, central=0, radius=0, mode=0, running=0, done=0, job_idx=0, total=0, rd_data=0, timeout_err=0. State returns to IDLE.
- Reset does not clear the job table or result buffer.
- Reset mid-batch aborts immediately. en never asserts in the cycle after rst.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - start=1 latches mode_in into mode and clamps job_count to DEPTH.
  - Clears job_idx and total.
  - If count=0, go to FINISH; otherwise go to ISSUE.
  - running=1 from the next cycle.
- ISSUE:
  - When busy=0 is sampled, register en=1 with central/radius = table[job_idx], then go to WAIT.
  - en is high for exactly one cycle. central/radius hold their value until the next issue.
  - valid seen in ISSUE is ignored.
- WAIT:
  - On valid=1: write candidate to result[job_idx] and add candidate to total (zero-extended, no saturation; max 64*64 fits in 14 bits).
  - If job_idx = count-1, go to FINISH; otherwise increment job_idx and go to ISSUE.
  - en is never re-asserted in WAIT, even if busy is still low right after issue.
- FINISH: done=1 for one cycle, running=0, go to IDLE. job_idx and total hold until the next start.
- start while running is ignored.
- load_we while running is ignored: no write.
- A simultaneous load_we and start in IDLE: the write is performed, and the batch uses the table contents after the write.
- The result buffer read is synchronous and usable at any time. Reading an address being written in the same cycle returns the old data.
- Minimum per-job overhead: 2 cycles plus SET latency.

Optional Feature:
- Macro: SET_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and is cleared on each entry to WAIT.
  - If it reaches TIMEOUT without valid: store 8'hFF in result[job_idx], add nothing to total, set timeout_err (sticky until rst or the next start), and continue with the next job as if valid had arrived.
- Undefined:
  - No counter and no timeout_err port; WAIT waits indefinitely.

Test Plan:
- Reset defaults: rst high 3 cycles during an active batch -> all outputs at reset values, en=0, state IDLE; a new start afterwards runs normally.
- Basic batch:
  - Stimulus: load 3 jobs; bench SET model holds busy 4 cycles after en, pulses valid with candidate=5,6,7.
  - Required: exactly 3 one-cycle en pulses with the matching central/radius; result[0..2]=5,6,7; total=18; one done pulse; mode stable through the run.
- Busy gating: model holds busy=1 for 10 cycles before the 2nd job -> en stays low until the cycle after busy=0 is sampled; no double issue.
- Edge counts:
  - job_count=0 -> done 2 cycles after start, no en.
  - job_count=64 with candidate=64 each -> total=4096, job_idx=63.
  - job_count=100 -> clamped to 64 jobs.
- Ignored inputs: start and load_we pulsed mid-batch -> batch unaffected, job table unchanged; spurious valid in ISSUE -> no result write.
- Timeout (SET_TIMEOUT_EN, TIMEOUT=16): model never asserts valid for job 1 -> result[1]=8'hFF, timeout_err=1, job 2 issued, done pulses at the end.
